// File: rtl/ahb_wr_pkg.sv
// Shared types and AHB-Lite encodings for the edge-detection result writer.
package ahb_wr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    ADDR,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/pixel_packer.sv
// Packs two 8-bit pixel pairs into one 32-bit word; the first pair lands in the upper half.
module pixel_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  pix_a,
  input  logic [7:0]  pix_b,
  output logic        word_full,
  output logic [31:0] word
);

  logic        half;
  logic [31:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half <= 1'b0;
    end else if (clear) begin
      half <= 1'b0;
    end else if (load) begin
      half <= ~half;
    end
  end

  // Data register carries no reset; it is only observed after a full word is loaded.
  always_ff @(posedge clk) begin
    if (load) begin
      if (half) begin
        word_q[15:0] <= {pix_a, pix_b};
      end else begin
        word_q[31:16] <= {pix_a, pix_b};
      end
    end
  end

  // High on the load that completes the word.
  assign word_full = load & half;
  assign word      = word_q;

endmodule

// File: rtl/ahb_write_ctrl.sv
// AHB-Lite single-beat word writer: packs pixel pairs and writes them to consecutive addresses.
module ahb_write_ctrl
  import ahb_wr_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      dest_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic             pix_valid,
  input  logic [7:0]       pix_a,
  input  logic [7:0]       pix_b,
  output logic             pix_ready,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic             busy,
  output logic             done,
  output logic             error
);

  state_t           state, next_state;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] remaining_q;
  logic [31:0]      hwdata_q;
  logic             error_q;
  logic             start_ok;
  logic             accept;
  logic             word_full;
  logic [31:0]      word;
  logic             data_ok;

  assign start_ok = start & ((state == IDLE) | (state == ERR));
  assign accept   = (state == COLLECT) & pix_valid;
  assign data_ok  = (state == DATA) & HREADY & ~HRESP;

  pixel_packer u_packer (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .load      (accept),
    .clear     (start_ok),
    .pix_a     (pix_a),
    .pix_b     (pix_b),
    .word_full (word_full),
    .word      (word)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, ERR: begin
        if (start) begin
          next_state = (num_words == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: if (word_full) next_state = ADDR;
      ADDR:    if (HREADY) next_state = DATA;
      DATA: begin
        // An ERROR response aborts on either of its two cycles.
        if (HRESP) begin
          next_state = ERR;
        end else if (HREADY) begin
          next_state = (remaining_q == CNT_W'(1)) ? DONE : COLLECT;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    HTRANS    = HTRANS_IDLE;
    HWRITE    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      COLLECT: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
      end
      ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HWRITE = 1'b1;
        busy   = 1'b1;
      end
      DATA:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q      <= 32'h0;
      remaining_q <= '0;
      hwdata_q    <= 32'hFFFF_FFFF;
      error_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q      <= dest_addr & ~32'h3;
        remaining_q <= num_words;
        error_q     <= 1'b0;
      end
      // Write data is captured once, as the address phase completes, and held through wait states.
      if ((state == ADDR) && HREADY) begin
        hwdata_q <= word;
      end
      if (data_ok) begin
        addr_q      <= addr_q + 32'd4;
        remaining_q <= remaining_q - CNT_W'(1);
      end
      if ((state == DATA) && HRESP) begin
        error_q <= 1'b1;
      end
    end
  end

  assign HADDR  = addr_q;
  assign HSIZE  = HSIZE_WORD;
  assign HWDATA = hwdata_q;
  assign error  = error_q;

endmodule

// File: doc/ahb_write_ctrl.md
Name: ahb_write_ctrl

Overview:
- AHB-Lite master write controller for the edge-detection result path.
- Collects processed pixel pairs from the filter core and packs two pairs into one 32-bit word.
- Issues single-beat NONSEQ word writes to consecutive destination addresses.
- Provides start/busy/done/error status to the top-level control FSM.

Parameters:
- CNT_W, 16, width of the word-count input and the internal remaining-words counter.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches dest_addr and num_words
- dest_addr  in  32  byte address of the first word; bits [1:0] ignored (forced 00)
- num_words  in  CNT_W  number of 32-bit words to write
- pix_valid  in  1  pixel pair valid
- pix_a  in  8  first pixel of pair
- pix_b  in  8  second pixel of pair
- pix_ready  out  1  pair accepted on an edge where pix_valid && pix_ready
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type
- HWRITE  out  1  AHB write enable
- HSIZE  out  3  AHB size
- HWDATA  out  32  AHB write data
- HREADY  in  1  slave ready
- HRESP  in  1  slave response; 1 = ERROR
- busy  out  1  high in any state except IDLE, DONE and ERR
- done  out  1  one-cycle pulse when all words are written
- error  out  1  sticky; cleared by the next accepted start

Behaviour:
- Reset values: HADDR=0, HTRANS=00, HWRITE=0, HSIZE=3'b010, HWDATA=32'hFFFF_FFFF, pix_ready=0, busy=0, done=0, error=0. State is IDLE.
- FSM states are IDLE, COLLECT, ADDR, DATA, DONE, ERR.
- IDLE:
  - start with num_words≠0 → COLLECT. Latch addr={dest_addr[31:2],2'b00}, remaining=num_words, half=0, clear error.
  - start with num_words=0 → DONE. No bus activity.
- COLLECT:
  - pix_ready=1.
  - On accept with half=0: word[31:16]={pix_a,pix_b}, half=1.
  - On accept with half=1: word[15:0]={pix_a,pix_b}, half=0, → ADDR.
- ADDR:
  - Outputs: HTRANS=10 (NONSEQ), HWRITE=1, HSIZE=010, HADDR=addr.
  - Holds until an edge with HREADY=1, then → DATA.
- DATA:
  - Outputs: HTRANS=00 (IDLE), HWRITE=0, HWDATA=word, held stable.
  - On an edge with HREADY=1 && HRESP=0: addr+=4 (wraps modulo 2^32), remaining-=1. Then → DONE if remaining was 1, else → COLLECT.
  - On an edge with HRESP=1 (either cycle of the two-cycle ERROR response): → ERR.
- DONE: done=1 for exactly one cycle, then → IDLE.
- ERR:
  - error=1, HTRANS=00, pix_ready=0.
  - Leaves only on start: → COLLECT (or → DONE if num_words=0).
- Latency: with HREADY tied high, pix_ready reasserts 2 cycles after the second pair of a word is accepted (ADDR 1 cycle, DATA 1 cycle). Throughput is 1 word per 4 cycles minimum.
- start while busy=1 is ignored.
- A partial word (half=1) is never written. The controller waits in COLLECT indefinitely.
- HWDATA changes only on the transition into DATA. It otherwise holds its last value.
- Asynchronous reset mid-transfer: outputs return to reset values immediately and the partial word is discarded.
- pix_valid outside COLLECT is ignored; no data is consumed.

Decomposition:
- Package ahb_wr_pkg: state enum (IDLE, COLLECT, ADDR, DATA, DONE, ERR); constants HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HSIZE_WORD=3'b010.
- Sub-module pixel_packer: the two-half word register with half flag. Interface: load, clear, pair in, word_full out, 32-bit word out.
- The FSM, address register and counter stay in ahb_write_ctrl.

Test Plan:
- Reset then idle → all outputs at reset values, HWDATA=32'hFFFF_FFFF, busy=0.
- start, dest_addr=0x1000_0003, num_words=2, HREADY=1; pairs (11,22),(33,44),(55,66),(77,88) → writes 0x1122_3344 @0x1000_0000 and 0x5566_7788 @0x1000_0004; done pulse 1 cycle; busy=0 after.
- Same run with HREADY=0 for 3 cycles in ADDR and 2 cycles in DATA → HADDR/HTRANS and HWDATA held stable across the waits; same words are written.
- HRESP=1, HREADY=0 then HRESP=1, HREADY=1 in DATA of word 1 → error=1, HTRANS=00, no done. Then start num_words=1 → error clears.
- start with num_words=0 → done pulse on the next cycle, HTRANS stays 00; a start issued while busy → ignored, counter unchanged.
- dest_addr=0xFFFF_FFFC, num_words=2 → second write @0x0000_0000. Assert HRESETn low after one pair → pix_ready=0, HTRANS=00 immediately.
